dmem_line_responder: RTL

//  Memory-side responder for the data-cache line interface. Accepts one 256-bit line

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_line_array.sv | 41 ++++
 rtl/dmem_line_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared sizing, FSM state encoding and line-index helper for the line responder.
// Latency: none, types and constants only.
// Backpressure: none, no logic here.
package dmem_pkg;

  localparam int DMEM_LINE_W  = 256;
  localparam int DMEM_DEPTH   = 512;
  localparam int DMEM_IDX_W   = 9;
  localparam int DMEM_LATENCY = 10;
  localparam int OFFSET_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } dmem_state_e;

  // Line number of a byte address. Callers truncate it to their index width,
  // which makes indexing wrap modulo the array depth.
  function automatic logic [31:0] line_idx(input logic [31:0] addr);
    return addr >> OFFSET_W;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: DEPTH x LINE_W line store with a synchronous write port and a registered read port.
// Latency: a write lands on the enabling edge, and read data appears on the edge after re_i is sampled.
// Backpressure: none. rdat_o holds the last line read until the next read or reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int LINE_W = DMEM_LINE_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int IDX_W  = DMEM_IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdat_i,
  output logic [LINE_W-1:0] rdat_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdat_q;

  // Storage write: contents are deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdat_i;
    end
  end

  // Read register: updates only on a read, so writes leave the output untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdat_q <= '0;
    end else if (re_i) begin
      rdat_q <= mem_q[idx_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: memory-side line read/write responder for the dcache controller. The optional perf counters are enabled by DMEM_PERF_CNT_EN.
// Latency: ack_o pulses LATENCY cycles after request acceptance, with one IDLE cycle before the next acceptance.
// Backpressure: a single request is outstanding. enable_i is sampled only in IDLE and inputs are latched at acceptance.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LINE_W  = DMEM_LINE_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int IDX_W   = DMEM_IDX_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  dmem_state_e       state_q;
  logic [7:0]        lat_q;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdat_q;
  logic              ack_q;

  logic              accept;
  logic              to_ack;
  logic              op_wr;
  logic [IDX_W-1:0]  op_idx;
  logic [LINE_W-1:0] op_dat;
  logic              arr_we;
  logic              arr_re;

  // Commit decode: the edge entering ACK performs the access. With LATENCY=1 that
  // edge is also the acceptance edge, so the live inputs are used instead of the latches.
  always_comb begin
    accept = (state_q == S_IDLE) && enable_i;
    to_ack = (accept && (LATENCY == 1)) || ((state_q == S_WAIT) && (lat_q == 8'd1));
    op_wr  = accept ? write_i : wr_q;
    op_idx = accept ? IDX_W'(line_idx(addr_i)) : idx_q;
    op_dat = accept ? data_i : wdat_q;
    arr_we = to_ack && op_wr && !rst_i;
    arr_re = to_ack && !op_wr && !rst_i;
  end

  // Request FSM: IDLE accepts, WAIT counts down the latency, ACK pulses for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= to_ack;
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            wr_q    <= write_i;
            idx_q   <= IDX_W'(line_idx(addr_i));
            wdat_q  <= data_i;
            lat_q   <= LAT_LOAD;
            state_q <= (LATENCY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          lat_q <= lat_q - 8'd1;
          if (lat_q == 8'd1) begin
            state_q <= S_ACK;
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  dmem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .idx_i  (op_idx),
    .wdat_i (op_dat),
    .rdat_o (data_o)
  );

  assign ack_o = ack_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Saturating completion counts, bumped on the edge entering ACK.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (to_ack && !op_wr && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
    if (to_ack && op_wr && (wr_cnt_q != 32'hFFFF_FFFF))  wr_cnt_d = wr_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule
